// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-requester arbiter.
// Indices are limited to ARB_MAX_N requesters.
package arb_pkg;

  localparam int unsigned ARB_MAX_N = 32;
  localparam int unsigned ARB_IDX_W = 5;

  localparam int unsigned ARB_MODE_RR    = 0;
  localparam int unsigned ARB_MODE_FIXED = 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  // Index of the set bit of a one-hot (or zero) vector; zero maps to 0.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_if.sv
// Arbiter bus bundle with test-driver, arbiter and passive-monitor views.
interface arb_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input logic clk
);

  logic           reset;
  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  modport test (
    input  clk, grant, grant_valid, grant_id,
    output reset, request
  );

  modport arb (
    input  clk, reset, request,
    output grant, grant_valid, grant_id
  );

  modport monitor (
    input clk, reset, request, grant, grant_valid, grant_id
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational rotated priority encoder: first unmasked request at or
// after start_ptr_i, wrapping modulo N.
module arb_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] start_ptr_i,
  input  logic [N-1:0]   mask_i,
  output logic [N-1:0]   winner_c_o,
  output logic           found_c_o
);

  logic [N-1:0] eligible;

  assign eligible = req_i & ~mask_i;

  always_comb begin
    winner_c_o = '0;
    found_c_o  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_c_o && eligible[IDW'((32'(start_ptr_i) + k) % N)]) begin
        winner_c_o[IDW'((32'(start_ptr_i) + k) % N)] = 1'b1;
        found_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_rr_n.sv
// N-requester arbiter: round-robin or fixed priority, with a bounded grant
// hold so a continuously requesting owner cannot starve the others.
module arb_rr_n
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MODE     = 0,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  localparam int unsigned HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  logic [N-1:0]   pick_mask;
  logic [N-1:0]   pick_win;
  logic           pick_found;
  logic [IDW-1:0] pick_start;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] win_next_ptr;
  logic           owner_req;
  logic           others_pend;
  logic           hold_expired;
  logic           keep_owner;

  // On hold expiry the owner is masked so the grant must move elsewhere.
  always_comb begin
    owner_req    = (state_q == GRANTED) && request[grant_id_q];
    others_pend  = |(request & ~grant_q);
    hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HCW'(HOLD_LAST));
    keep_owner   = owner_req && !(hold_expired && others_pend);
    pick_mask    = (owner_req && hold_expired) ? grant_q : '0;
    pick_start   = (MODE == ARB_MODE_FIXED) ? '0 : rr_ptr_q;
  end

  arb_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i       (request),
    .start_ptr_i (pick_start),
    .mask_i      (pick_mask),
    .winner_c_o  (pick_win),
    .found_c_o   (pick_found)
  );

  assign win_idx      = IDW'(onehot_to_idx(ARB_MAX_N'(pick_win)));
  assign win_next_ptr = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);

  // Next-state and next-output selection.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    hold_cnt_d    = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = GRANTED;
          grant_d       = pick_win;
          grant_valid_d = 1'b1;
          grant_id_d    = win_idx;
          rr_ptr_d      = win_next_ptr;
          hold_cnt_d    = '0;
        end
      end
      GRANTED: begin
        if (keep_owner) begin
          if ((MAX_HOLD != 0) && (hold_cnt_q < HCW'(HOLD_LAST))) begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end else if (pick_found) begin
          grant_d       = pick_win;
          grant_valid_d = 1'b1;
          grant_id_d    = win_idx;
          rr_ptr_d      = win_next_ptr;
          hold_cnt_d    = '0;
        end else begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
          hold_cnt_d    = '0;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
        hold_cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grant_q));
  a_grant_valid: assert property (@(posedge clk) disable iff (!reset)
    grant_valid_q == (|grant_q));
  a_grant_req: assert property (@(posedge clk) disable iff (!reset)
    (grant_q & ~$past(request)) == '0);

endmodule

// File: tb/tb_arb_rr_n.sv
// Directed bench for arb_rr_n: one round-robin and two fixed-priority
// instances checked every cycle against a behavioural model plus literals.
module tb_arb_rr_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  arb_if #(.N(4)) bus (.clk(clk));

  logic [3:0] req_f;
  logic [3:0] g_f0, g_f4;
  logic       v_f0, v_f4;
  logic [1:0] id_f0, id_f4;

  arb_rr_n #(.N(4), .MODE(0), .MAX_HOLD(4)) u_rr (
    .clk         (clk),
    .reset       (bus.reset),
    .request     (bus.request),
    .grant       (bus.grant),
    .grant_valid (bus.grant_valid),
    .grant_id    (bus.grant_id)
  );

  arb_rr_n #(.N(4), .MODE(1), .MAX_HOLD(0)) u_fx0 (
    .clk         (clk),
    .reset       (bus.reset),
    .request     (req_f),
    .grant       (g_f0),
    .grant_valid (v_f0),
    .grant_id    (id_f0)
  );

  arb_rr_n #(.N(4), .MODE(1), .MAX_HOLD(4)) u_fx4 (
    .clk         (clk),
    .reset       (bus.reset),
    .request     (req_f),
    .grant       (g_f4),
    .grant_valid (v_f4),
    .grant_id    (id_f4)
  );

  int checks = 0;
  int errors = 0;

  // Model state per instance: owner index (-1 = none), hold count, rr pointer.
  int m_own  [3] = '{-1, -1, -1};
  int m_cnt  [3] = '{0, 0, 0};
  int m_ptr  [3] = '{0, 0, 0};
  int m_mode [3] = '{0, 1, 1};
  int m_maxh [3] = '{4, 0, 4};

  logic [3:0] vec [20] = '{4'b0101, 4'b0101, 4'b0111, 4'b0110, 4'b0010,
                           4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011,
                           4'b1001, 4'b0000, 4'b1100, 4'b0100, 4'b1111,
                           4'b1111, 4'b0001, 4'b1110, 4'b1000, 4'b0000};

  logic [3:0] cont_rr [17] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0010, 4'b0010, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b0100, 4'b0100,
                               4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b0001};

  logic [3:0] cont_f4 [16] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b0100, 4'b0100,
                               4'b0010, 4'b0010, 4'b0010, 4'b0010,
                               4'b0100, 4'b0100, 4'b0100, 4'b0100};

  function automatic int pick(input logic [3:0] r, input int start, input int skip);
    int w;
    int i;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      i = (start + k) % 4;
      if (w < 0 && r[2'(i)] && i != skip) w = i;
    end
    return w;
  endfunction

  task automatic model_step(input int u, input logic [3:0] r);
    int         own;
    logic [3:0] others;
    bit         owner_on;
    bit         expired;
    own      = m_own[u];
    others   = (own >= 0) ? (r & ~(4'b0001 << own)) : r;
    owner_on = (own >= 0) && r[2'(own)];
    expired  = (m_maxh[u] != 0) && (m_cnt[u] >= m_maxh[u] - 1);
    if (owner_on && !(expired && others != 4'b0000)) begin
      if (m_maxh[u] != 0 && !expired) m_cnt[u] = m_cnt[u] + 1;
    end else begin
      own      = pick(r, (m_mode[u] == 1) ? 0 : m_ptr[u], own);
      m_own[u] = own;
      m_cnt[u] = 0;
      if (own >= 0) m_ptr[u] = (own + 1) % 4;
    end
  endtask

  always @(posedge clk or negedge bus.reset) begin
    if (!bus.reset) begin
      for (int u = 0; u < 3; u++) begin
        m_own[u] = -1;
        m_cnt[u] = 0;
        m_ptr[u] = 0;
      end
    end else begin
      model_step(0, bus.request);
      model_step(1, req_f);
      model_step(2, req_f);
    end
  end

  function automatic logic [3:0] m_grant(input int u);
    return (m_own[u] < 0) ? 4'b0000 : 4'(1 << m_own[u]);
  endfunction

  function automatic logic [1:0] m_id(input int u);
    return (m_own[u] < 0) ? 2'd0 : 2'(m_own[u]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("rr_grant", 32'(bus.grant), 32'(m_grant(0)));
    chk("rr_valid", 32'(bus.grant_valid), 32'(m_own[0] >= 0));
    chk("rr_id", 32'(bus.grant_id), 32'(m_id(0)));
    chk("fx0_grant", 32'(g_f0), 32'(m_grant(1)));
    chk("fx0_valid", 32'(v_f0), 32'(m_own[1] >= 0));
    chk("fx0_id", 32'(id_f0), 32'(m_id(1)));
    chk("fx4_grant", 32'(g_f4), 32'(m_grant(2)));
    chk("fx4_valid", 32'(v_f4), 32'(m_own[2] >= 0));
    chk("fx4_id", 32'(id_f4), 32'(m_id(2)));
  endtask

  // Drive at a falling edge, let one rising edge pass, compare at the next fall.
  task automatic step_io(input logic [3:0] r, input logic [3:0] rf);
    bus.request = r;
    req_f       = rf;
    @(negedge clk);
    cmp_model();
  endtask

  initial begin
    bus.reset   = 1'b0;
    bus.request = 4'b0000;
    req_f       = 4'b0000;
    repeat (2) @(negedge clk);
    cmp_model();
    chk("reset_grant", 32'(bus.grant), 32'h0);
    chk("reset_valid", 32'(bus.grant_valid), 32'h0);
    chk("reset_id", 32'(bus.grant_id), 32'h0);
    bus.reset = 1'b1;

    // Async reset mid-grant, then regrant after release.
    step_io(4'b0001, 4'b0000);
    chk("first_grant", 32'(bus.grant), 32'h1);
    #1 bus.reset = 1'b0;
    #1;
    chk("async_clr_grant", 32'(bus.grant), 32'h0);
    chk("async_clr_valid", 32'(bus.grant_valid), 32'h0);
    @(negedge clk);
    cmp_model();
    bus.reset = 1'b1;
    step_io(4'b0001, 4'b0000);
    chk("regrant", 32'(bus.grant), 32'h1);

    // Single requester held well past the hold limit.
    step_io(4'b0000, 4'b0000);
    step_io(4'b0100, 4'b0000);
    chk("single_grant", 32'(bus.grant), 32'h4);
    chk("single_id", 32'(bus.grant_id), 32'h2);
    chk("single_valid", 32'(bus.grant_valid), 32'h1);
    for (int i = 0; i < 20; i++) begin
      step_io(4'b0100, 4'b0000);
      chk("single_hold", 32'(bus.grant), 32'h4);
    end

    // Drop to idle, then pointer wrap from 3 to index 1.
    step_io(4'b0000, 4'b0000);
    chk("idle_grant", 32'(bus.grant), 32'h0);
    chk("idle_valid", 32'(bus.grant_valid), 32'h0);
    chk("idle_id", 32'(bus.grant_id), 32'h0);
    step_io(4'b0010, 4'b0000);
    chk("wrap_grant", 32'(bus.grant), 32'h2);

    // Zero-bubble handoff from owner 0 to requester 3.
    step_io(4'b0000, 4'b0000);
    step_io(4'b0001, 4'b0000);
    step_io(4'b1001, 4'b0000);
    chk("hand_own", 32'(bus.grant), 32'h1);
    step_io(4'b1000, 4'b0000);
    chk("hand_new", 32'(bus.grant), 32'h8);
    chk("hand_id", 32'(bus.grant_id), 32'h3);

    // Full contention rotation.
    step_io(4'b0000, 4'b0000);
    for (int i = 0; i < 17; i++) begin
      step_io(4'b1111, 4'b0000);
      chk("contend_rr", 32'(bus.grant), 32'(cont_rr[i]));
    end
    step_io(4'b0000, 4'b0000);

    // Fixed priority, unlimited and bounded hold.
    for (int i = 0; i < 16; i++) begin
      step_io(4'b0000, 4'b1110);
      chk("fixed_nohold", 32'(g_f0), 32'h2);
      chk("fixed_hold4", 32'(g_f4), 32'(cont_f4[i]));
    end
    step_io(4'b0000, 4'b0000);

    // Mixed vectors, model-checked only.
    for (int i = 0; i < 20; i++) begin
      step_io(vec[i], vec[i]);
    end

    // Reset during contention; arbitration restarts from pointer 0.
    repeat (3) step_io(4'b1111, 4'b1110);
    #1 bus.reset = 1'b0;
    #1;
    chk("mid_rst_rr", 32'(bus.grant), 32'h0);
    chk("mid_rst_id", 32'(bus.grant_id), 32'h0);
    chk("mid_rst_f4", 32'(g_f4), 32'h0);
    @(negedge clk);
    cmp_model();
    bus.reset = 1'b1;
    step_io(4'b1111, 4'b1110);
    chk("post_rst_rr", 32'(bus.grant), 32'h1);
    chk("post_rst_f0", 32'(g_f0), 32'h2);
    step_io(4'b1111, 4'b1110);
    chk("post_rst_keep", 32'(bus.grant), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_rr_n.md
Name: arb_rr_n

Overview:
- Parametrised N-requester arbiter; next generation of the 2-requester arb block that sits behind the arb_if modport.
- Adds configurable requester count, round-robin or fixed-priority mode, a bounded grant hold (anti-starvation), and grant index/valid outputs.
- Sits between requesting masters and a shared resource; the testbench drives it through the test/arb/monitor modport split.

Parameters:
- N, 4, number of requesters (>= 2).
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others wait; 0 = unlimited.
- IDW, $clog2(N), grant index width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- request  input  N  per-requester request level; held high for as long as the resource is wanted.
- grant  output  N  one-hot registered grant, or all-zero.
- grant_valid  output  1  high when any grant bit is set.
- grant_id  output  IDW  index of the current owner; 0 when grant_valid is low.

Behaviour:
- Reset (reset low, asynchronous) clears all state: grant=0, grant_valid=0, grant_id=0, hold_cnt=0, rr_ptr=0, state=IDLE. Outputs clear immediately, not at the next edge. Release is synchronous to clk.
- All outputs are registered. A request sampled at edge k produces its grant at edge k+1.
- State IDLE:
  - Request nonzero → pick the winner → GRANTED; hold_cnt=0.
  - Otherwise stay in IDLE.
- State GRANTED, evaluated at each edge:
  - (a) Owner request still high, and either MAX_HOLD=0, hold_cnt<MAX_HOLD-1, or no other request pending → keep grant; hold_cnt increments and saturates at MAX_HOLD-1.
  - (b) Owner request still high, hold_cnt==MAX_HOLD-1, and another request pending → grant moves to the winner chosen with the owner masked out; hold_cnt=0.
  - (c) Owner request low and others pending → grant moves to the winner in the same edge (zero-bubble handoff); hold_cnt=0.
  - (d) Owner request low and no others pending → grant=0, go to IDLE.
- Winner selection, round-robin (MODE=0):
  - Search starts at index rr_ptr and wraps modulo N.
  - On every new grant to index i, rr_ptr <= (i+1) mod N; wraps from N-1 to 0.
- Winner selection, fixed (MODE=1):
  - Lowest set index wins; rr_ptr is unused.
  - Hold expiry passes the grant to the lowest-index other requester. Starvation of high indices is allowed in this mode.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_id matches grant.
  - A grant never goes to an index whose request was low at the sampling edge.
- Simultaneous events: owner drop and hold expiry in the same cycle are handled by rule (c). Requests that rise in the same cycle as a handoff take part in that handoff.
- Reset asserted mid-grant clears everything. Arbitration after reset release begins again from rr_ptr=0.

Decomposition:
- Package arb_pkg:
  - typedef enum {IDLE, GRANTED} arb_state_e.
  - Mode constants ARB_MODE_RR=0 and ARB_MODE_FIXED=1.
  - Function onehot_to_idx.
- Sub-module arb_pick:
  - Purely combinational rotated priority encoder.
  - Inputs: req[N], start_ptr, mask[N]. Outputs: onehot winner, found.
  - Fixed mode drives start_ptr=0. The top level holds the FSM, hold counter and rr_ptr.
- Monitor modport / interface: grant, grant_valid and grant_id are inputs only.

Test Plan (N=4, MAX_HOLD=4, MODE=0 unless stated):
- Async reset: request=4'b0001 held until grant=0001; drive reset low between edges → grant=0, grant_valid=0 immediately. Release reset → grant=0001 again one edge later.
- Single requester: request=4'b0100 at edge 0 → grant=0100, grant_id=2, grant_valid=1 from edge 1. Hold the request for 20 cycles → grant stays 0100 (counter saturates, no other requesters).
- Full contention: request=4'b1111 continuous → grant 0001 for 4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then back to 0001.
- Zero-bubble handoff: owner 0 granted with request=1001; drop bit 0 → grant=1000 at the next edge, with no all-zero cycle in between.
- Drop to idle: sole owner 2 deasserts → grant=0, grant_valid=0, grant_id=0 next edge. Then request=0010 → grant=0010 (rr_ptr=3, wraps to index 1).
- MODE=1: request=4'b1110 continuous.
  - With MAX_HOLD=0 → grant=0010 forever.
  - With MAX_HOLD=4 → 0010 ×4, 0100 ×4, 0010 ×4 …; bit 3 is never granted.
